// File: rtl/ga_pkg.sv
// Shared constants, state encoding and helpers for the GA pipeline stages.
package ga_pkg;
   localparam int NUM_IND  = 100;
   localparam int IND_BITS = 75;
   localparam int POP_BITS = NUM_IND * IND_BITS;
   localparam int IDX_W    = $clog2(NUM_IND);
   localparam int BIT_W    = $clog2(POP_BITS);
   localparam int POS_W    = 7;
   localparam int CNT_W    = 7;

   localparam int          LFSR_W        = 32;
   localparam logic [31:0] LFSR_TAPS     = 32'h8020_0003;
   localparam logic [31:0] LFSR_SEED_DEF = 32'hACE1_2024;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } ga_state_t;

   // 127 < 2*IND_BITS, so one conditional subtract folds any 7-bit draw into range.
   function automatic logic [POS_W-1:0] wrap_pos(input logic [POS_W-1:0] p);
      return (p < POS_W'(IND_BITS)) ? p : p - POS_W'(IND_BITS);
   endfunction
endpackage

// File: rtl/ga_mutate_if.sv
// Request/result bundle between the population-state controller and the mutation stage.
interface ga_mutate_if;
   import ga_pkg::*;

   logic                start;
   logic [POP_BITS-1:0] sel_pop;
   logic [POP_BITS-1:0] mut_pop;
   logic                done;
   logic                busy;
   logic [CNT_W-1:0]    flip_count;

   modport master (output start, sel_pop, input mut_pop, done, busy, flip_count);
   modport slave  (input start, sel_pop, output mut_pop, done, busy, flip_count);
endinterface

// File: rtl/ga_lfsr.sv
// 32-bit right-shifting Galois LFSR with enable; a zero seed is forced to 1.
module ga_lfsr
   import ga_pkg::*;
#(
   parameter logic [31:0] SEED = LFSR_SEED_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   output logic [LFSR_W-1:0] q
);
   localparam logic [31:0] SEED_EFF = (SEED == 32'd0) ? 32'd1 : SEED;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         q <= SEED_EFF;
      else if (en)
         q <= {1'b0, q[LFSR_W-1:1]} ^ (q[0] ? LFSR_TAPS : '0);
   end
endmodule

// File: rtl/ga_mutate.sv
// Mutation stage: latch a population, walk one individual per clock, flip one random bit with p=MUT_RATE/256.
// Build option GA_MUT_ELITISM_EN protects individual 0 from mutation.
//
// state | meaning
// IDLE  | waiting for start, no valid result
// RUN   | processing individual idx, busy=1
// DONE  | mut_pop/flip_count valid, done=1, start accepted as in IDLE
module ga_mutate
   import ga_pkg::*;
#(
   parameter int          MUT_RATE  = 8,
   parameter logic [31:0] LFSR_SEED = LFSR_SEED_DEF
) (
   input  logic        clk,
   input  logic        rst,
   ga_mutate_if.slave  bus
);
   ga_state_t           state, state_nx;
   logic [POP_BITS-1:0] work, work_nx;
   logic [IDX_W-1:0]    idx;
   logic [CNT_W-1:0]    flip_cnt, flip_cnt_nx;
   logic [LFSR_W-1:0]   q;
   logic                hit, do_flip, last;
   logic [POS_W-1:0]    pos;
   logic [BIT_W-1:0]    bit_idx;
   logic                lfsr_unused;

   ga_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
      .clk (clk),
      .rst (rst),
      .en  (state == RUN),
      .q   (q)
   );

   assign hit         = {1'b0, q[7:0]} < 9'(MUT_RATE);
   assign pos         = wrap_pos(q[14:8]);
   assign bit_idx     = BIT_W'(idx) * BIT_W'(IND_BITS) + BIT_W'(pos);
   assign last        = (idx == IDX_W'(NUM_IND - 1));
   assign lfsr_unused = ^q[LFSR_W-1:15];

   always_comb begin
      state_nx    = state;
      work_nx     = work;
      flip_cnt_nx = flip_cnt;
      do_flip     = 1'b0;
      case (state)
         IDLE, DONE: if (bus.start) state_nx = RUN;
         RUN: begin
            do_flip = hit;
`ifdef GA_MUT_ELITISM_EN
            if (idx == '0) do_flip = 1'b0;
`endif
            if (do_flip) work_nx[bit_idx] = ~work[bit_idx];
            if (do_flip && flip_cnt != '1) flip_cnt_nx = flip_cnt + 1'b1;
            if (last) state_nx = DONE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= IDLE;
         work           <= '0;
         idx            <= '0;
         flip_cnt       <= '0;
         bus.mut_pop    <= '0;
         bus.flip_count <= '0;
      end else begin
         state <= state_nx;
         case (state)
            IDLE, DONE: begin
               if (bus.start) begin
                  work     <= bus.sel_pop;
                  idx      <= '0;
                  flip_cnt <= '0;
               end
            end
            RUN: begin
               work     <= work_nx;
               idx      <= idx + 1'b1;
               flip_cnt <= flip_cnt_nx;
               // Publish on the edge that processes the last individual so done follows next cycle.
               if (last) begin
                  bus.mut_pop    <= work_nx;
                  bus.flip_count <= flip_cnt_nx;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.busy = (state == RUN);
   assign bus.done = (state == DONE);
endmodule

// File: tb/tb_ga_mutate.sv
// Scoreboard bench for ga_mutate: three instances (MUT_RATE 0, 8, 256) with a reference mutation model.
module tb_ga_mutate;
   import ga_pkg::*;

   typedef struct {
      logic [POP_BITS-1:0] pop;
      int                  fc;
      int                  done_cyc;
      bit                  zero_src;
      bit                  hand;
   } exp_t;

   logic clk = 1'b0;
   logic rst0, rst8, rst256;
   int   cyc = 0;
   int   n_vec = 0, n_miss = 0;

   exp_t sb0[$], sb8[$], sb256[$];
   logic [31:0] m8, m256;

   ga_mutate_if if0 ();
   ga_mutate_if if8 ();
   ga_mutate_if if256 ();

   ga_mutate #(.MUT_RATE(0))   u_dut0   (.clk(clk), .rst(rst0),   .bus(if0.slave));
   ga_mutate #(.MUT_RATE(8))   u_dut8   (.clk(clk), .rst(rst8),   .bus(if8.slave));
   ga_mutate #(.MUT_RATE(256)) u_dut256 (.clk(clk), .rst(rst256), .bus(if256.slave));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk_int(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_miss++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk_pop(input string name, input logic [POP_BITS-1:0] act,
                          input logic [POP_BITS-1:0] exp);
      int first;
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         first = -1;
         for (int i = 0; i < POP_BITS; i++)
            if (first < 0 && act[i] !== exp[i]) first = i;
         $display("FAIL %s: population differs, first bit %0d got %b expected %b, %0d bits differ",
                  name, first, act[first], exp[first], $countones(act ^ exp));
      end
   endtask

   function automatic logic [31:0] lfsr_step(input logic [31:0] q);
      return {1'b0, q[31:1]} ^ (q[0] ? 32'h8020_0003 : 32'h0);
   endfunction

   task automatic model_run(input logic [31:0] q_in, input logic [POP_BITS-1:0] src, input int rate,
                            output logic [POP_BITS-1:0] res, output int fc, output logic [31:0] q_out);
      logic [31:0] q;
      int p, pos;
      bit elig;
      q = q_in; res = src; fc = 0;
      for (int i = 0; i < NUM_IND; i++) begin
         p    = int'(q[14:8]);
         pos  = (p >= IND_BITS) ? p - IND_BITS : p;
         elig = 1'b1;
`ifdef GA_MUT_ELITISM_EN
         if (i == 0) elig = 1'b0;
`endif
         if (elig && int'(q[7:0]) < rate) begin
            res[i*IND_BITS + pos] = ~res[i*IND_BITS + pos];
            if (fc < 127) fc++;
         end
         q = lfsr_step(q);
      end
      q_out = q;
   endtask

   task automatic check_run(input string tag, input exp_t e, input logic [POP_BITS-1:0] pop,
                            input logic [CNT_W-1:0] fc);
      int bad, want;
      chk_int({tag, "_latency"}, cyc, e.done_cyc);
      chk_pop({tag, "_mut_pop"}, pop, e.pop);
      chk_int({tag, "_flip_count"}, int'(fc), e.fc);
      if (e.zero_src) begin
         bad = 0;
         for (int i = 0; i < NUM_IND; i++) begin
            want = 1;
`ifdef GA_MUT_ELITISM_EN
            if (i == 0) want = 0;
`endif
            if ($countones(pop[i*IND_BITS +: IND_BITS]) != want) bad++;
         end
         chk_int({tag, "_bad_slice_popcount"}, bad, 0);
      end
      if (e.hand) begin
         // seed ACE12024: ind0 draws p=32; next state 56709012 gives ind1 p=16 -> bit 91
`ifdef GA_MUT_ELITISM_EN
         chk_int({tag, "_ind0_bit32"}, int'(pop[32]), 0);
`else
         chk_int({tag, "_ind0_bit32"}, int'(pop[32]), 1);
`endif
         chk_int({tag, "_ind1_bit91"}, int'(pop[91]), 1);
      end
   endtask

   bit d0_q = 0, d8_q = 0, d256_q = 0;
   int busy0_run = 0, busy8_run = 0;

   always @(negedge clk) begin
      if (!rst0) begin
         if (if0.busy) busy0_run++;
         else if (busy0_run != 0) begin chk_int("u0_busy_len", busy0_run, NUM_IND); busy0_run = 0; end
         if (if0.done && !d0_q) begin
            if (sb0.size() != 0) check_run("u0", sb0.pop_front(), if0.mut_pop, if0.flip_count);
            else begin n_vec++; n_miss++; $display("FAIL u0_unexpected_done at cycle %0d", cyc); end
         end
      end
      d0_q = if0.done;
   end

   always @(negedge clk) begin
      if (!rst8) begin
         if (if8.busy) busy8_run++;
         else if (busy8_run != 0) begin chk_int("u8_busy_len", busy8_run, NUM_IND); busy8_run = 0; end
         if (if8.done && !d8_q) begin
            if (sb8.size() != 0) check_run("u8", sb8.pop_front(), if8.mut_pop, if8.flip_count);
            else begin n_vec++; n_miss++; $display("FAIL u8_unexpected_done at cycle %0d", cyc); end
         end
      end
      d8_q = if8.done;
   end

   always @(negedge clk) begin
      if (!rst256 && if256.done && !d256_q) begin
         if (sb256.size() != 0) check_run("u256", sb256.pop_front(), if256.mut_pop, if256.flip_count);
         else begin n_vec++; n_miss++; $display("FAIL u256_unexpected_done at cycle %0d", cyc); end
      end
      d256_q = if256.done;
   end

   task automatic wait_idle(input string name);
      int t = 0;
      while ((sb0.size() + sb8.size() + sb256.size()) != 0 && t < 400) begin
         @(negedge clk); t++;
      end
      chk_int({name, "_scoreboard_drained"}, sb0.size() + sb8.size() + sb256.size(), 0);
      @(negedge clk);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t e, first256;
      logic [POP_BITS-1:0] res, pat;
      int fc, t;

      rst0 = 1; rst8 = 1; rst256 = 1;
      if0.start = 0;   if8.start = 0;   if256.start = 0;
      if0.sel_pop = '0; if8.sel_pop = '0; if256.sel_pop = '0;
      m8 = LFSR_SEED_DEF; m256 = LFSR_SEED_DEF;
      repeat (2) @(negedge clk);
      chk_int("rst_u0_done", int'(if0.done), 0);
      chk_int("rst_u0_busy", int'(if0.busy), 0);
      chk_int("rst_u8_flip_count", int'(if8.flip_count), 0);
      chk_int("rst_u256_busy", int'(if256.busy), 0);
      chk_pop("rst_u256_mut_pop", if256.mut_pop, '0);
      rst0 = 0; rst8 = 0; rst256 = 0;
      @(negedge clk);

      // run A: rate 0 with all ones, rate 256 with zeros
      if0.sel_pop = '1;
      if256.sel_pop = '0;
      e.pop = '1; e.fc = 0; e.done_cyc = cyc + 1 + NUM_IND; e.zero_src = 0; e.hand = 0;
      sb0.push_back(e);
      model_run(m256, '0, 256, res, fc, m256);
      e.pop = res; e.zero_src = 1; e.hand = 1;
`ifdef GA_MUT_ELITISM_EN
      e.fc = 99;
`else
      e.fc = 100;
`endif
      sb256.push_back(e);
      first256 = e;
      if0.start = 1; if256.start = 1;
      @(negedge clk);
      if0.start = 0; if256.start = 0;
      wait_idle("run_a");

      // run B: rate 8, ignored start at RUN cycle 30, sel_pop changes mid-run
      for (int i = 0; i < POP_BITS; i++) pat[i] = (i % 3 == 0);
      if8.sel_pop = pat;
      model_run(m8, pat, 8, res, fc, m8);
      e.pop = res; e.fc = fc; e.done_cyc = cyc + 1 + NUM_IND; e.zero_src = 0; e.hand = 0;
      sb8.push_back(e);
      if8.start = 1;
      @(negedge clk);
      if8.start = 0;
      repeat (29) @(negedge clk);
      if8.start = 1;
      if8.sel_pop = ~pat;
      @(negedge clk);
      if8.start = 0;
      repeat (50) @(negedge clk);
      if8.start = 1;
      t = 0;
      while (!if8.done && t < 200) begin @(negedge clk); t++; end
      chk_int("u8_done_seen", int'(if8.done), 1);

      // run C: start held across DONE is accepted on the next edge
      model_run(m8, ~pat, 8, res, fc, m8);
      e.pop = res; e.fc = fc; e.done_cyc = cyc + 1 + NUM_IND;
      sb8.push_back(e);
      @(negedge clk);
      if8.start = 0;
      chk_int("u8_done_one_cycle", int'(if8.done), 0);
      chk_int("u8_busy_again", int'(if8.busy), 1);
      if8.sel_pop = pat;
      wait_idle("run_c");

      // run D: second rate-256 run continues the LFSR stream
      model_run(m256, '0, 256, res, fc, m256);
      e.pop = res; e.fc = first256.fc; e.done_cyc = cyc + 1 + NUM_IND; e.zero_src = 1; e.hand = 0;
      sb256.push_back(e);
      if256.start = 1;
      @(negedge clk);
      if256.start = 0;
      wait_idle("run_d");

      // run E: reset mid-run, then a rerun must match the first run bit-exactly
      if256.start = 1;
      @(negedge clk);
      if256.start = 0;
      repeat (49) @(negedge clk);
      chk_int("u256_busy_before_abort", int'(if256.busy), 1);
      rst256 = 1;
      #1;
      chk_int("abort_done", int'(if256.done), 0);
      chk_int("abort_busy", int'(if256.busy), 0);
      chk_int("abort_flip_count", int'(if256.flip_count), 0);
      chk_pop("abort_mut_pop", if256.mut_pop, '0);
      @(negedge clk);
      rst256 = 0;
      m256 = LFSR_SEED_DEF;
      @(negedge clk);
      e = first256;
      e.done_cyc = cyc + 1 + NUM_IND;
      sb256.push_back(e);
      if256.start = 1;
      @(negedge clk);
      if256.start = 0;
      wait_idle("run_e");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule

// File: doc/ga_mutate.md
Name: ga_mutate

Overview:
Mutation stage of the genetic-algorithm pipeline. It sits directly downstream of selection and feeds its result back to the population-state controller. On a start request it latches the selected population and walks it one individual per clock. For each individual it flips one pseudo-randomly chosen bit with probability MUT_RATE/256, then presents the mutated population with a level done flag.

Parameters:
NUM_IND, 100, individuals per population
IND_BITS, 75, bits per individual; NUM_IND*IND_BITS = 7500 = population bus width
MUT_RATE, 8, per-individual mutation probability numerator over 256; legal range 0..256
LFSR_SEED, 32'hACE1_2024, LFSR reset value; 0 is replaced by 1

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
start  in  1  mutate request (mut_start from controller)
sel_pop  in  NUM_IND*IND_BITS  selected population; individual i occupies bits [i*IND_BITS +: IND_BITS]
mut_pop  out  NUM_IND*IND_BITS  mutated population, registered
done  out  1  level; high while result valid (mut_done to controller)
busy  out  1  high while walking individuals
flip_count  out  7  number of individuals mutated in last run

Behaviour:
- Reset (async, rst=1), all outputs and state:
  - mut_pop=0, done=0, busy=0, flip_count=0
  - idx=0, state=IDLE, LFSR=LFSR_SEED (or 1 if the seed is 0)
- State machine IDLE -> RUN -> DONE:
  - IDLE: start=1 at a clock edge copies sel_pop into the working register, clears idx and the flip counter, and moves to RUN. busy=1 from the next cycle.
  - RUN: each cycle processes individual idx, advances the LFSR once and increments idx. After processing idx=NUM_IND-1 the machine moves to DONE.
  - DONE: the working register is copied to mut_pop and flip_count is updated on the same edge. done=1 and busy=0 from the following cycle. done stays high until the next accepted start.
  - start=1 in DONE is accepted exactly as in IDLE: done drops the next cycle and mut_pop holds its old value until the new run finishes.
- Latency: start sampled at edge N gives busy=1 for cycles N+1 .. N+NUM_IND. done=1 from cycle N+NUM_IND+1 (101 cycles for the defaults).
- start while busy is ignored. sel_pop changes during RUN have no effect because the population is latched at start.
- Random fields taken from the current LFSR state q:
  - r = q[7:0]; the individual mutates if r < MUT_RATE (9-bit unsigned compare). MUT_RATE=0 never mutates; MUT_RATE=256 always mutates.
  - p = q[14:8] (7 bits); bit position = p if p < IND_BITS, else p-IND_BITS. One conditional subtract is sufficient because 127 < 2*IND_BITS. The resulting bias is accepted.
  - A mutation inverts exactly that one bit of individual idx in the working register.
- LFSR: 32-bit Galois, polynomial x^32+x^22+x^2+x+1 (taps mask 32'h8020_0003). It advances only in RUN, so results depend solely on seed, sel_pop and the number of runs since reset.
- flip_count saturates at 127; it cannot overflow with the defaults.
- rst asserted mid-run aborts immediately to the reset values. The next run after reset reproduces the first-run result bit-exactly.

Optional Feature:
GA_MUT_ELITISM_EN
- Defined: individual 0 (the fittest, which selection places in slot 0) is never mutated. The LFSR still advances during its cycle, so the random streams for individuals 1..NUM_IND-1 are identical to the non-elitist build. flip_count excludes slot 0.
- Undefined: all individuals are eligible.

Decomposition:
- Package ga_pkg holds:
  - NUM_IND, IND_BITS, POP_BITS = NUM_IND*IND_BITS
  - LFSR width, taps mask and default seed
  - state encoding: IDLE=2'd0, RUN=2'd1, DONE=2'd2
- Sub-module ga_lfsr: 32-bit Galois LFSR with enable, seed parameter and async reset. It is reusable by selection and crossover.

Test Plan:
- MUT_RATE=0, sel_pop=all ones, start pulse 1 cycle -> done rises 101 cycles later; mut_pop == sel_pop; flip_count=0; busy high for exactly 100 cycles.
- MUT_RATE=256, sel_pop=0 -> every 75-bit slice of mut_pop has popcount exactly 1; flip_count=100; all set-bit positions are < 75.
- MUT_RATE=256, rst pulsed at cycle 50 of RUN -> done=0, busy=0, mut_pop=0 immediately. A re-run gives mut_pop identical to a clean first run from reset.
- Second start pulse during RUN at cycle 30 is ignored: done still rises at cycle 101 of the first run. start held high across DONE -> one-cycle done, then busy again.
- GA_MUT_ELITISM_EN defined, MUT_RATE=256, sel_pop=0 -> slice 0 == 0; slices 1..99 equal those of the non-elitist build; flip_count=99.
